// File: rtl/serial_adder_core.sv
// Multi-cycle adder: BPC bits of a+b+cin per clock through one shared slice; SERIAL_ADD_OVF_EN adds the ovf output.
// Latency WIDTH/BPC cycles from accept; one op in flight, in_ready low until the result is taken via out_ready.
module serial_adder_core #(
  parameter int WIDTH = 8,
  parameter int BPC   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int STEPS = WIDTH / BPC;
  localparam int CW    = $clog2(STEPS + 1);

  if (WIDTH < 1 || BPC < 1 || (WIDTH % BPC) != 0) begin : g_param_check
    $error("serial_adder_core: BPC must be >= 1 and divide WIDTH");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, acc_q, sum_q;
  logic [WIDTH-1:0] acc_d;
  logic [CW-1:0]    count_q;
  logic             carry_q, in_ready_q, out_valid_q, cout_q, busy_q;
  logic [BPC-1:0]   slice_d;
  logic             slice_c_d;
`ifdef SERIAL_ADD_OVF_EN
  logic             a_msb_q, b_msb_q, ovf_q;
`endif

  // Partial sums build up in acc_q so the visible sum keeps the previous result until completion.
  always_comb begin
    {slice_c_d, slice_d} = {1'b0, a_q[BPC-1:0]} + {1'b0, b_q[BPC-1:0]} + {{BPC{1'b0}}, carry_q};
    acc_d = (acc_q >> BPC) | (WIDTH'(slice_d) << (WIDTH - BPC));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      sum_q       <= '0;
      count_q     <= '0;
      carry_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      cout_q      <= 1'b0;
      busy_q      <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      a_msb_q     <= 1'b0;
      b_msb_q     <= 1'b0;
      ovf_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            a_q        <= a;
            b_q        <= b;
            carry_q    <= cin;
            count_q    <= '0;
            state_q    <= RUN;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
`ifdef SERIAL_ADD_OVF_EN
            a_msb_q    <= a[WIDTH-1];
            b_msb_q    <= b[WIDTH-1];
`endif
          end
        end
        RUN: begin
          a_q     <= a_q >> BPC;
          b_q     <= b_q >> BPC;
          carry_q <= slice_c_d;
          acc_q   <= acc_d;
          count_q <= count_q + CW'(1);
          if (count_q == CW'(STEPS - 1)) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            sum_q       <= acc_d;
            cout_q      <= slice_c_d;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q       <= (a_msb_q == b_msb_q) && (slice_d[BPC-1] != a_msb_q);
`endif
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign busy      = busy_q;
`ifdef SERIAL_ADD_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule
